note_scheduler: RTL

//  Sequences a song ROM into NUM_VOICES note_player instances. Fetches 16-bit song entries,

---
 rtl/note_scheduler.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/note_scheduler.sv
// -----------------------------------------------------------------------------
// note_scheduler
//
// Reads a song from a synchronous-read ROM and hands each note to one of
// NUM_VOICES note_player voices. A note goes to the lowest-numbered free voice.
// That voice's note/duration registers are written, and its load strobe pulses
// for one cycle. Rest entries are timed in 1/48 s beats.
//
// Song entry format (16 bits):
//   [15]   ADV  : 0 = note, 1 = rest (dur != 0) or end of song (dur == 0)
//   [14:9] note
//   [8:3]  dur
//   [2:0]  reserved, ignored
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high; aborts a song immediately
//   start       pulse: begin the song at address 0 (accepted only when idle)
//   play        1 = run, 0 = pause (sequencer, rest timer, voice release frozen)
//   beat        one-cycle 1/48 s tick
//   rom_addr    song ROM address (ROM returns data one cycle later)
//   rom_data    song ROM entry
//   voice_done  per-voice done_with_note
//   voice_load  per-voice one-cycle load_new_note
//   voice_note  6 bits per voice, voice i at [6*i +: 6]
//   voice_dur   6 bits per voice, voice i at [6*i +: 6]
//   busy        high from start acceptance until the song ends
//   song_done   one-cycle pulse at the end of the song
//
// Build option
//   SONG_LOOP_EN : when defined, the song restarts from address 0 at its end.
//                  busy stays high, and song_done still pulses once per pass.
// -----------------------------------------------------------------------------
module note_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    play,
    input  logic                    beat,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [15:0]             rom_data,
    input  logic [NUM_VOICES-1:0]   voice_done,
    output logic [NUM_VOICES-1:0]   voice_load,
    output logic [6*NUM_VOICES-1:0] voice_note,
    output logic [6*NUM_VOICES-1:0] voice_dur,
    output logic                    busy,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ALLOC  = 3'd3,
        ST_REST   = 3'd4,
        ST_END    = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]     rom_addr_reg;
    logic                  busy_reg;
    logic                  song_done_reg;
    logic [5:0]            rest_cnt_reg;
    logic [5:0]            entry_note_reg;
    logic [5:0]            entry_dur_reg;
    logic [NUM_VOICES-1:0] voice_load_reg;
    logic [NUM_VOICES-1:0] voice_busy;

    // Entry fields straight from the ROM output, which is valid in DECODE.
    logic       rom_adv;
    logic [5:0] rom_note;
    logic [5:0] rom_dur;
    logic       unused_rsvd;

    assign rom_adv     = rom_data[15];
    assign rom_note    = rom_data[14:9];
    assign rom_dur     = rom_data[8:3];
    assign unused_rsvd = ^rom_data[2:0];

    // Lowest-index free voice. taken[i] is set when any voice below i is free.
    logic [NUM_VOICES-1:0] free_vec;
    logic [NUM_VOICES-1:0] alloc_sel;
    logic [NUM_VOICES:0]   taken;
    logic                  any_free;

    assign free_vec = ~voice_busy;
    assign taken[0] = 1'b0;
    assign any_free = taken[NUM_VOICES];

    // Strobes produced by the sequencer and consumed by the datapath.
    logic start_fire;
    logic latch_entry;
    logic rest_load;
    logic rest_dec;
    logic advance;
    logic alloc_fire;
    logic end_fire;
    logic last_addr;

    assign last_addr = (rom_addr_reg == {ADDR_W{1'b1}});

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_fire  = 1'b0;
        latch_entry = 1'b0;
        rest_load   = 1'b0;
        rest_dec    = 1'b0;
        advance     = 1'b0;
        alloc_fire  = 1'b0;
        end_fire    = 1'b0;

        // While paused nothing moves; beats and start are ignored as well.
        if (play) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        start_fire = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_next = ST_DECODE;
                end
                ST_DECODE: begin
                    latch_entry = 1'b1;
                    if (!rom_adv) begin
                        state_next = ST_ALLOC;
                    end else if (rom_dur != 6'd0) begin
                        rest_load  = 1'b1;
                        state_next = ST_REST;
                    end else begin
                        state_next = ST_END;
                    end
                end
                ST_ALLOC: begin
                    // With no free voice the note waits here; it is never dropped.
                    if (any_free) begin
                        alloc_fire = 1'b1;
                        advance    = 1'b1;
                    end
                end
                ST_REST: begin
                    if (rest_cnt_reg == 6'd0) begin
                        advance = 1'b1;
                    end else if (beat) begin
                        rest_dec = 1'b1;
                    end
                end
                ST_END: begin
                    end_fire = 1'b1;
`ifdef SONG_LOOP_EN
                    state_next = ST_FETCH;
`else
                    state_next = ST_IDLE;
`endif
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            // Leaving the last ROM location wraps the address.
            // That entry is treated as the end of the song.
            if (advance) begin
                state_next = last_addr ? ST_END : ST_FETCH;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Shared datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_reg   <= '0;
            busy_reg       <= 1'b0;
            song_done_reg  <= 1'b0;
            rest_cnt_reg   <= 6'd0;
            entry_note_reg <= 6'd0;
            entry_dur_reg  <= 6'd0;
            voice_load_reg <= '0;
        end else begin
            song_done_reg <= end_fire;
            // Load strobe lasts exactly one cycle, even if play drops meanwhile.
            voice_load_reg <= alloc_fire ? alloc_sel : '0;

            if (start_fire) begin
                rom_addr_reg <= '0;
                busy_reg     <= 1'b1;
            end else if (advance) begin
                rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
            end else if (end_fire) begin
`ifdef SONG_LOOP_EN
                rom_addr_reg <= '0;
`else
                busy_reg     <= 1'b0;
`endif
            end

            if (latch_entry) begin
                entry_note_reg <= rom_note;
                entry_dur_reg  <= rom_dur;
            end

            if (rest_load) begin
                rest_cnt_reg <= rom_dur;
            end else if (rest_dec) begin
                rest_cnt_reg <= rest_cnt_reg - 6'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-voice state
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic       busy_v_reg;
            logic [1:0] mask_reg;
            logic [5:0] note_reg;
            logic [5:0] dur_reg;
            logic       claim;

            assign claim = alloc_fire & alloc_sel[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    busy_v_reg <= 1'b0;
                    mask_reg   <= 2'd0;
                    note_reg   <= 6'd0;
                    dur_reg    <= 6'd0;
                end else if (claim) begin
                    busy_v_reg <= 1'b1;
                    mask_reg   <= 2'd2;
                    note_reg   <= entry_note_reg;
                    dur_reg    <= entry_dur_reg;
                end else begin
                    // For two cycles after a load, done still reflects the
                    // previous note and is ignored.
                    if (mask_reg != 2'd0) begin
                        mask_reg <= mask_reg - 2'd1;
                    end
                    if (play && voice_done[gi] && (mask_reg == 2'd0)) begin
                        busy_v_reg <= 1'b0;
                    end
                end
            end

            assign voice_busy[gi]      = busy_v_reg;
            assign taken[gi+1]         = taken[gi] | free_vec[gi];
            assign alloc_sel[gi]       = free_vec[gi] & ~taken[gi];
            assign voice_note[6*gi +: 6] = note_reg;
            assign voice_dur[6*gi +: 6]  = dur_reg;
        end
    endgenerate

    assign rom_addr   = rom_addr_reg;
    assign voice_load = voice_load_reg;
    assign busy       = busy_reg;
    assign song_done  = song_done_reg;

endmodule
